// File: rtl/inst_encoder_pkg.sv
// Shared format codes, request record and immediate range helper for the
// RISC-V instruction encoder.
package inst_encoder_pkg;

    localparam logic [2:0] TYPE_I = 3'd0;
    localparam logic [2:0] TYPE_S = 3'd1;
    localparam logic [2:0] TYPE_B = 3'd2;
    localparam logic [2:0] TYPE_U = 3'd3;
    localparam logic [2:0] TYPE_J = 3'd4;
    localparam logic [2:0] TYPE_R = 3'd5;

    typedef struct packed {
        logic [2:0]  itype;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // True when imm[31:msb] are all equal, i.e. imm is a sign extension of imm[msb:0].
    function automatic logic imm_fits(input logic [31:0] imm, input logic [4:0] msb);
        logic [31:0] hi;
        hi = $unsigned($signed(imm) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational instruction packing and immediate representability check.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  itype,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    always_comb begin
        inst = '0;
        err  = 1'b0;
        case (itype)
            TYPE_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            TYPE_I: begin
                inst = {imm[11:0], rs1, funct3, rd, opcode};
                err  = !imm_fits(imm, 5'd11);
            end
            TYPE_S: begin
                inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !imm_fits(imm, 5'd11);
            end
            TYPE_B: begin
                inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = imm[0] || !imm_fits(imm, 5'd12);
            end
            TYPE_U: begin
                inst = {imm[31:12], rd, opcode};
                err  = |imm[11:0];
            end
            TYPE_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = imm[0] || !imm_fits(imm, 5'd20);
            end
            default: begin
                inst = '0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RISC-V instruction encoder with saturating error count.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] err_cnt
);

    enc_req_t    s1_req;
    logic        s1_valid;
    logic        advance;
    logic        in_fire;
    logic [31:0] pack_inst;
    logic        pack_err;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;
    assign in_fire  = in_valid && in_ready;

    // S1 registers the raw request so nothing combinational reaches the outputs from in_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_req   <= '{itype:  in_type,
                          opcode: in_opcode,
                          rd:     in_rd,
                          rs1:    in_rs1,
                          rs2:    in_rs2,
                          funct3: in_funct3,
                          funct7: in_funct7,
                          imm:    in_imm};
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    inst_pack u_pack (
        .itype  (s1_req.itype),
        .opcode (s1_req.opcode),
        .rd     (s1_req.rd),
        .rs1    (s1_req.rs1),
        .rs2    (s1_req.rs2),
        .funct3 (s1_req.funct3),
        .funct7 (s1_req.funct7),
        .imm    (s1_req.imm),
        .inst   (pack_inst),
        .err    (pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= pack_inst;
                out_err  <= pack_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule
